// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the pattern lookup used by seg7_reader and seg7dec.
// Segment patterns are active-low, bits 6:0 = g..a.
package seg7_pkg;

  localparam logic [6:0] PAT_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58, 7'h00, 7'h10
  };
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  localparam logic [3:0] VAL_BLANK = 4'hF;
  localparam logic [3:0] VAL_ERR   = 4'hE;

  typedef struct packed {
    logic [3:0] val;
    logic       err;
  } seg7_dec_t;

  // Exact match against the digit table; blank is legal, anything else is an error.
  function automatic seg7_dec_t seg7_lookup(input logic [6:0] segs);
    seg7_dec_t dec;
    dec.val = VAL_ERR;
    dec.err = 1'b1;
    if (segs == PAT_BLANK) begin
      dec.val = VAL_BLANK;
      dec.err = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (segs == PAT_DIGIT[i]) begin
        dec.val = 4'(i);
        dec.err = 1'b0;
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/seg7_pat2val.sv
// Combinational decode of one active-low 8-bit segment pattern into a digit value and error flag.
// With SEG7_READER_DP_EN the dp bit is reported separately instead of being part of the match.
module seg7_pat2val
  import seg7_pkg::*;
(
  input  logic [7:0] pat,
  output logic [3:0] val,
  output logic       err
`ifdef SEG7_READER_DP_EN
  ,
  output logic       dp
`endif
);

  seg7_dec_t dec;

  always_comb begin
    dec = seg7_lookup(pat[6:0]);
`ifdef SEG7_READER_DP_EN
    dp = ~pat[7];
`else
    // A lit dp is never part of a legal character in this build.
    if (!pat[7]) begin
      dec.val = VAL_ERR;
      dec.err = 1'b1;
    end
`endif
  end

  assign val = dec.val;
  assign err = dec.err;

endmodule

// File: rtl/seg7_reader.sv
// Samples a two-digit seven-segment display, waits for the pattern to settle, and hands the
// decoded pair to a consumer over a valid/ready handshake. Optional dp output: SEG7_READER_DP_EN.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg7led_in  [1:0],
  output logic [3:0] seg7val_out [1:0],
  output logic [1:0] seg7err_out,
`ifdef SEG7_READER_DP_EN
  output logic [1:0] dp_out,
`endif
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] sample_q, prev_q, acc_q;
  logic [3:0]  val_q [1:0];
  logic [1:0]  err_q;
  logic        latch;

  logic [3:0]  dec_val [1:0];
  logic [1:0]  dec_err;

`ifdef SEG7_READER_DP_EN
  logic [1:0]  dec_dp;
  logic [1:0]  dp_q;
`endif

  seg7_pat2val u_dec0 (
    .pat (sample_q[7:0]),
    .val (dec_val[0]),
`ifdef SEG7_READER_DP_EN
    .dp  (dec_dp[0]),
`endif
    .err (dec_err[0])
  );

  seg7_pat2val u_dec1 (
    .pat (sample_q[15:8]),
    .val (dec_val[1]),
`ifdef SEG7_READER_DP_EN
    .dp  (dec_dp[1]),
`endif
    .err (dec_err[1])
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_q != acc_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (sample_q == acc_q) begin
          state_d = ST_IDLE;
        end else if (sample_q != prev_q) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_PRESENT;
          latch   = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_PRESENT: begin
        // Changes seen while presenting start a fresh settle after the handshake.
        if (out_ready) begin
          cnt_d   = '0;
          state_d = (sample_q != acc_q) ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sample_q <= '1;
      prev_q   <= '1;
      acc_q    <= '1;
      val_q[0] <= VAL_BLANK;
      val_q[1] <= VAL_BLANK;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= sample_q;
      sample_q <= {seg7led_in[1], seg7led_in[0]};
      if (latch) begin
        acc_q    <= sample_q;
        val_q[0] <= dec_val[0];
        val_q[1] <= dec_val[1];
        err_q    <= dec_err;
      end
    end
  end

`ifdef SEG7_READER_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= '0;
    end else if (latch) begin
      dp_q <= dec_dp;
    end
  end

  assign dp_out = dp_q;
`endif

  assign seg7val_out[0] = val_q[0];
  assign seg7val_out[1] = val_q[1];
  assign seg7err_out    = err_q;
  assign out_valid      = (state_q == ST_PRESENT);

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed table, handshake/reset sequences, and random
// stimulus against a run-length based reference model.
module tb_seg7_reader;

  localparam int S = 4;

  localparam logic [6:0] REF_PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58, 7'h00, 7'h10
  };

  logic       clk;
  logic       rst_n;
  logic [7:0] led [1:0];
  logic [3:0] seg7val_out [1:0];
  logic [1:0] seg7err_out;
  logic       out_valid;
  logic       out_ready;
`ifdef SEG7_READER_DP_EN
  logic [1:0] dp_out;
`endif

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg7led_in  (led),
    .seg7val_out (seg7val_out),
    .seg7err_out (seg7err_out),
`ifdef SEG7_READER_DP_EN
    .dp_out      (dp_out),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: a pair is accepted once it has been sampled unchanged for S+1
  // consecutive clocks and differs from the last accepted pair; after a handshake a new
  // acceptance needs at least S more clocks.
  logic        m_present;
  logic [15:0] m_acc;
  logic [15:0] m_last;
  int          m_run;
  int          m_block;
  int          edge_n = 0;
  logic [3:0]  m_val [1:0];
  logic [1:0]  m_err;
  logic [1:0]  m_dp;

  typedef struct {
    logic [7:0] i0, i1;
    logic [3:0] v0, v1;
    logic       e0, e1, d0, d1;
  } vec_t;

  vec_t tbl [8];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void ref_dec(input logic [7:0] p, output logic [3:0] v, output logic e,
                                  output logic d);
    logic legal;
    d = ~p[7];
`ifdef SEG7_READER_DP_EN
    legal = 1'b1;
`else
    legal = p[7];
`endif
    v = 4'hE;
    e = 1'b1;
    if (legal) begin
      if (p[6:0] == 7'h7F) begin
        v = 4'hF;
        e = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
        if (p[6:0] == REF_PAT[i]) begin
          v = 4'(i);
          e = 1'b0;
        end
      end
    end
  endfunction

  function automatic void m_reset();
    m_present = 1'b0;
    m_acc     = 16'hFFFF;
    m_last    = 16'hFFFF;
    m_run     = 1;
    m_block   = 0;
    m_val[0]  = 4'hF;
    m_val[1]  = 4'hF;
    m_err     = 2'b00;
    m_dp      = 2'b00;
  endfunction

  function automatic void model_step(input logic [15:0] smp, input logic rdy);
    edge_n++;
    if (m_present) begin
      if (rdy) begin
        m_present = 1'b0;
        m_block   = edge_n + S;
      end
    end else if (edge_n >= m_block && m_run >= S + 1 && m_last != m_acc) begin
      m_present = 1'b1;
      m_acc     = m_last;
      ref_dec(m_last[7:0], m_val[0], m_err[0], m_dp[0]);
      ref_dec(m_last[15:8], m_val[1], m_err[1], m_dp[1]);
    end
    if (smp == m_last) begin
      if (m_run < 100000) m_run++;
    end else begin
      m_last = smp;
      m_run  = 1;
    end
  endfunction

  task automatic check_outputs();
    check("valid", out_valid, m_present);
    check("val0", seg7val_out[0], m_val[0]);
    check("val1", seg7val_out[1], m_val[1]);
    check("err", seg7err_out, m_err);
`ifdef SEG7_READER_DP_EN
    check("dp", dp_out, m_dp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step({led[1], led[0]}, out_ready);
    #1;
    check_outputs();
  endtask

  task automatic set_led(input logic [7:0] a0, input logic [7:0] a1);
    led[0] = a0;
    led[1] = a1;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < limit) begin
      tick();
      cyc++;
    end
    check("valid_timeout", out_valid, 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  saw;

    tbl[0] = '{8'hF9, 8'hA4, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hB0, 8'h99, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h92, 8'h82, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hD8, 8'h80, 4'd7, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h90, 8'hFF, 4'd9, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SEG7_READER_DP_EN
    tbl[5] = '{8'h41, 8'hC1, 4'd0, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h40, 4'hF, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    tbl[5] = '{8'h41, 8'hC1, 4'hE, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h40, 4'hE, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    tbl[7] = '{8'hFF, 8'hC0, 4'hF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_led(8'hFF, 8'hFF);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_val0", seg7val_out[0], 4'hF);
    check("rst_val1", seg7val_out[1], 4'hF);
    check("rst_err", seg7err_out, 2'b00);
`ifdef SEG7_READER_DP_EN
    check("rst_dp", dp_out, 2'b00);
`endif
    rst_n = 1'b1;

    // First pattern after reset: valid appears S+2 clocks after the change.
    set_led(8'hC0, 8'hC0);
    wait_valid(40, cyc);
    check("latency", cyc, S + 2);
    check("lat_val0", seg7val_out[0], 4'd0);
    check("lat_val1", seg7val_out[1], 4'd0);
    check("lat_err", seg7err_out, 2'b00);
    handshake();

    for (int i = 0; i < 8; i++) begin
      set_led(tbl[i].i0, tbl[i].i1);
      wait_valid(40, cyc);
      check("tbl_val0", seg7val_out[0], tbl[i].v0);
      check("tbl_val1", seg7val_out[1], tbl[i].v1);
      check("tbl_err", seg7err_out, {tbl[i].e1, tbl[i].e0});
`ifdef SEG7_READER_DP_EN
      check("tbl_dp", dp_out, {tbl[i].d1, tbl[i].d0});
`endif
      handshake();
    end

    // Pattern flipping every two clocks never settles.
    saw = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((i / 2) % 2 == 0) set_led(8'hF9, 8'hF9);
      else set_led(8'hA4, 8'hA4);
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("toggle_no_valid", saw, 1'b0);
    set_led(8'hA4, 8'hA4);
    wait_valid(40, cyc);
    check("toggle_val0", seg7val_out[0], 4'd2);
    check("toggle_val1", seg7val_out[1], 4'd2);
    handshake();

    // Outputs hold while the consumer stalls; the change is presented afterwards.
    set_led(8'h99, 8'h99);
    wait_valid(40, cyc);
    set_led(8'h92, 8'h92);
    repeat (20) tick();
    check("hold_valid", out_valid, 1'b1);
    check("hold_val0", seg7val_out[0], 4'd4);
    check("hold_val1", seg7val_out[1], 4'd4);
    handshake();
    wait_valid(40, cyc);
    check("second_val0", seg7val_out[0], 4'd5);
    check("second_val1", seg7val_out[1], 4'd5);
    handshake();

    // Asynchronous reset while presenting drops the pending pair.
    set_led(8'hC0, 8'hF9);
    wait_valid(40, cyc);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_val0", seg7val_out[0], 4'hF);
    check("arst_val1", seg7val_out[1], 4'hF);
    check("arst_err", seg7err_out, 2'b00);
    m_reset();
    set_led(8'hFF, 8'hFF);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("arst_no_valid", saw, 1'b0);
    out_ready = 1'b0;
    set_led(8'h90, 8'h90);
    wait_valid(40, cyc);
    check("arst_new_val0", seg7val_out[0], 4'd9);
    handshake();

    // Random segments of random length with a randomly stalling consumer.
    for (int seg = 0; seg < 600; seg++) begin
      logic [7:0] p [2];
      int hold;
      for (int d = 0; d < 2; d++) begin
        case ($urandom_range(0, 3))
          0: p[d] = {1'b1, REF_PAT[$urandom_range(0, 9)]};
          1: p[d] = 8'hFF;
          2: p[d] = 8'($urandom);
          default: p[d] = {1'b0, REF_PAT[$urandom_range(0, 9)]};
        endcase
      end
      set_led(p[0], p[1]);
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        out_ready = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted (legal range 1..255).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port seg7led_in[1:0]  input  8 each  active-low segment patterns; bit7 = dp, bits6:0 = g..a.
REQ-005 SHALL provide port seg7val_out[1:0]  output  4 each  decoded digit values.
REQ-006 SHALL provide port seg7err_out[1:0]  output  1 each  pattern not a legal digit or blank.
REQ-007 SHALL provide port out_valid  output  1  decoded pair available.
REQ-008 SHALL provide port out_ready  input  1  consumer accepts pair when high with out_valid.

Function
REQ-009 SHALL register seg7led_in every cycle into sample regs; all decisions use registered samples.
REQ-010 SHALL decode per digit: bits6:0 exact match of 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x58,0x00,0x10 -> 0..9; 0x7F -> 4'hF (blank, err 0); any other -> 4'hE with err 1.
REQ-011 SHALL implement FSM IDLE, SETTLE, PRESENT.
REQ-012 IDLE: if sample pair differs from accepted pair -> SETTLE, stability counter cleared to 0.
REQ-013 SETTLE: counter increments while sample pair equals previous cycle's pair; any change restarts counter at 0.
REQ-014 SETTLE: when counter reaches STABLE_CYCLES-1 with unchanged pair -> PRESENT, latching decoded values/errs into output regs and pair into accepted regs; STABLE_CYCLES=1 means PRESENT the cycle after the change is sampled.
REQ-015 SETTLE: if pair returns to accepted pair before acceptance -> IDLE, no output.
REQ-016 PRESENT: out_valid=1; seg7val_out, seg7err_out, (dp_out) SHALL hold constant until out_valid & out_ready.
REQ-017 Handshake completes in the cycle out_valid & out_ready; out_valid deasserts next cycle; input changes during PRESENT are not lost: after handshake, next state is SETTLE (counter 0) if sample differs from accepted, else IDLE.
REQ-018 out_ready high while out_valid low SHALL have no effect; out_valid SHALL NOT depend combinationally on out_ready.
REQ-019 Counter width 8 bits; counter saturates, never wraps.

Reset
REQ-020 On rst_n low: state IDLE, counter 0, sample and accepted regs 8'hFF, seg7val_out 4'hF each, seg7err_out 0, out_valid 0, dp_out 0.
REQ-021 Reset asserted mid-SETTLE or mid-PRESENT SHALL discard pending pair without handshake.

Configuration
REQ-022 Macro SEG7_READER_DP_EN: when defined, bit7 is excluded from digit match and adds output dp_out[1:0] (1 = dp lit, bit7 low), latched with values.
REQ-023 Without SEG7_READER_DP_EN: no dp_out port; bit7 must be 1 for a legal pattern, bit7 low forces 4'hE/err 1.

Structure
REQ-024 Package seg7_pkg SHALL hold the ten digit pattern constants, blank pattern 7'h7F, and codes VAL_BLANK=4'hF, VAL_ERR=4'hE; shared with seg7dec.
REQ-025 Sub-module seg7_pat2val (combinational pattern->value/err) SHALL be instantiated once per digit.

Verification
REQ-026 Reset, then both inputs 0xC0 held -> out_valid rises 1+STABLE_CYCLES+1 cycles after change, values 0/0, errs 0.
REQ-027 Input 0xF9 toggled to 0xA4 every 2 cycles (STABLE_CYCLES=4) -> out_valid never asserts; then held 0xA4 -> value 2.
REQ-028 out_ready low 20 cycles in PRESENT while input changes 0x99->0x92 -> outputs hold 4; after handshake, second PRESENT reports 5.
REQ-029 Input 0xFF -> 4'hF err 0; input 0x41 -> 4'hE err 1 (without DP_EN) or value 0, dp_out 1 (with DP_EN).
REQ-030 rst_n pulsed low mid-PRESENT -> out_valid 0 and outputs 4'hF asynchronously; no handshake after release until new stable change.
